// File: rtl/mem_req_demux2_if.sv
// Core-side request/response bus plus the two target ports of mem_req_demux2.
interface mem_req_demux2_if;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned MW = 4;

   // core request / response
   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_addr;
   logic          req_we;
   logic [DW-1:0] req_wdata;
   logic [MW-1:0] req_wmask;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;

   // target request side (fields shared by both targets)
   logic          t0_valid;
   logic          t1_valid;
   logic          t0_ready;
   logic          t1_ready;
   logic [AW-1:0] t_addr;
   logic          t_we;
   logic [DW-1:0] t_wdata;
   logic [MW-1:0] t_wmask;

   // target response side
   logic          t0_rsp_valid;
   logic          t1_rsp_valid;
   logic [DW-1:0] t0_rsp_rdata;
   logic [DW-1:0] t1_rsp_rdata;

   // environment view: drives the core request and the target responses
   modport master (
      output req_valid, req_addr, req_we, req_wdata, req_wmask,
      output t0_ready, t1_ready, t0_rsp_valid, t1_rsp_valid, t0_rsp_rdata, t1_rsp_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  t0_valid, t1_valid, t_addr, t_we, t_wdata, t_wmask
   );

   // demux view
   modport slave (
      input  req_valid, req_addr, req_we, req_wdata, req_wmask,
      input  t0_ready, t1_ready, t0_rsp_valid, t1_rsp_valid, t0_rsp_rdata, t1_rsp_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output t0_valid, t1_valid, t_addr, t_we, t_wdata, t_wmask
   );
endinterface

// File: rtl/mem_req_demux2.sv
// Address-based 1-to-2 demux of the data-memory request stream (t0 = RAM,
// t1 = MMIO). One transaction in flight, registered target fields, response
// timeout and misaligned-address error.
module mem_req_demux2 #(
   parameter logic [31:0] MMIO_BASE      = 32'h8000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic           clk,
   input  logic           reset,
   mem_req_demux2_if.slave bus
);
   localparam int unsigned   TW         = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state;
   logic          sel;
   logic [TW-1:0] timer;

   logic          sel_ready;
   logic          sel_rsp_valid;
   logic [31:0]   sel_rsp_rdata;
   logic          timer_done;
   logic          req_mmio;
   logic          req_misaligned;

   // Selected-target view and request decode.
   always_comb begin
      sel_ready      = sel ? bus.t1_ready     : bus.t0_ready;
      sel_rsp_valid  = sel ? bus.t1_rsp_valid : bus.t0_rsp_valid;
      sel_rsp_rdata  = sel ? bus.t1_rsp_rdata : bus.t0_rsp_rdata;
      timer_done     = (timer == TIMER_LAST);
      req_mmio       = (bus.req_addr >= MMIO_BASE);
      req_misaligned = (bus.req_addr[1:0] != 2'b00);
   end

   // Transaction FSM with registered outputs. In REQ only a target response
   // counts as completion, so a timeout beats a same-cycle t_ready there.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         sel           <= 1'b0;
         timer         <= '0;
         bus.req_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.t0_valid  <= 1'b0;
         bus.t1_valid  <= 1'b0;
         bus.t_addr    <= '0;
         bus.t_we      <= 1'b0;
         bus.t_wdata   <= '0;
         bus.t_wmask   <= '0;
      end else begin
         bus.rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  bus.t_addr  <= bus.req_addr;
                  bus.t_we    <= bus.req_we;
                  bus.t_wdata <= bus.req_wdata;
                  bus.t_wmask <= bus.req_wmask;
                  sel         <= req_mmio;
                  if (req_misaligned) begin
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= 1'b1;
                     bus.rsp_rdata <= '0;
                  end else begin
                     state         <= REQ;
                     timer         <= '0;
                     bus.req_ready <= 1'b0;
                     bus.t0_valid  <= !req_mmio;
                     bus.t1_valid  <= req_mmio;
                  end
               end
            end
            REQ: begin
               timer <= timer + TW'(1);
               if (timer_done) begin
                  state         <= IDLE;
                  bus.req_ready <= 1'b1;
                  bus.t0_valid  <= 1'b0;
                  bus.t1_valid  <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_rdata <= '0;
               end else if (sel_ready) begin
                  state        <= RESP;
                  bus.t0_valid <= 1'b0;
                  bus.t1_valid <= 1'b0;
               end
            end
            RESP: begin
               timer <= timer + TW'(1);
               if (sel_rsp_valid) begin
                  state         <= IDLE;
                  bus.req_ready <= 1'b1;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b0;
                  bus.rsp_rdata <= bus.t_we ? 32'd0 : sel_rsp_rdata;
               end else if (timer_done) begin
                  state         <= IDLE;
                  bus.req_ready <= 1'b1;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_rdata <= '0;
               end
            end
            default: begin
               state         <= IDLE;
               bus.req_ready <= 1'b1;
               bus.t0_valid  <= 1'b0;
               bus.t1_valid  <= 1'b0;
            end
         endcase
      end
   end
endmodule
